// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: on-chip word RAM plus a small MMIO bank (timer/compare, LED, switches, scratch).
// Latency: read data is registered, valid the cycle after an sram_en strobe; sram_rdata holds while idle.
// Backpressure: none; every strobed access is accepted and served in a single cycle.
module data_sram_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000,
  parameter logic [31:0] MMIO_MASK = 32'hffff_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic        timer_match
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  // MMIO word offsets (byte offset >> 2)
  localparam logic [13:0] OFF_TIMER   = 14'h0000;
  localparam logic [13:0] OFF_LED     = 14'h0001;
  localparam logic [13:0] OFF_SWITCH  = 14'h0002;
  localparam logic [13:0] OFF_SCRATCH = 14'h0003;
  localparam logic [13:0] OFF_CMP     = 14'h0004;
  localparam logic [13:0] OFF_STATUS  = 14'h0005;

  logic [31:0] r_ram [0:RAM_DEPTH-1];
  logic [31:0] r_rdata;
  logic [31:0] r_timer;
  logic [31:0] r_cmp;
  logic [31:0] r_scratch;
  logic [15:0] r_led;
  logic        r_match;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;

  logic              w_mmio;
  logic              w_wr;
  logic              w_mmio_wr;
  logic [13:0]       w_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_timer_wr;
  logic [31:0]       w_timer_inc;
  logic              w_match_set;
  logic              w_match_clr;
  logic [31:0]       w_mmio_rdata;
  logic [31:0]       w_rd_next;
  logic              w_unused;

  // Byte-lane merge of write data into an existing word
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] we);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign w_mmio      = (sram_addr & MMIO_MASK) == MMIO_BASE;
  assign w_wr        = sram_en & (sram_we != 4'b0000);
  assign w_mmio_wr   = w_wr & w_mmio;
  assign w_off       = sram_addr[15:2];
  assign w_ram_idx   = sram_addr[RAM_AW+1:2];
  assign w_timer_wr  = w_mmio_wr & (w_off == OFF_TIMER);
  assign w_timer_inc = r_timer + 32'd1;
  // Compare only against a real increment; a cycle that loads TIMER never matches
  assign w_match_set = (r_cmp != 32'd0) & ~w_timer_wr & (w_timer_inc == r_cmp);
  assign w_match_clr = w_mmio_wr & (w_off == OFF_STATUS) & sram_we[0] & sram_wdata[0];
  assign w_unused    = ^sram_addr[1:0];

  // MMIO read mux: current (pre-update) register contents
  always_comb begin
    w_mmio_rdata = 32'd0;
    case (w_off)
      OFF_TIMER:   w_mmio_rdata = r_timer;
      OFF_LED:     w_mmio_rdata = {16'd0, r_led};
      OFF_SWITCH:  w_mmio_rdata = {24'd0, r_sw_sync};
      OFF_SCRATCH: w_mmio_rdata = r_scratch;
      OFF_CMP:     w_mmio_rdata = r_cmp;
      OFF_STATUS:  w_mmio_rdata = {31'd0, r_match};
      default:     w_mmio_rdata = 32'd0;
    endcase
  end

  assign w_rd_next = w_mmio ? w_mmio_rdata : r_ram[w_ram_idx];

  // RAM array: byte-enabled write, no reset; reset in the same cycle drops the write
  always_ff @(posedge clk) begin
    if (!reset && w_wr && !w_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) r_ram[w_ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

  // Registered read data, captured only on strobed accesses (read-before-write)
  always_ff @(posedge clk) begin
    if (reset)        r_rdata <= 32'd0;
    else if (sram_en) r_rdata <= w_rd_next;
  end

  // Free-running timer; a write replaces that cycle's increment
  always_ff @(posedge clk) begin
    if (reset)           r_timer <= 32'd0;
    else if (w_timer_wr) r_timer <= merge(r_timer, sram_wdata, sram_we);
    else                 r_timer <= w_timer_inc;
  end

  // Writable registers: LED (low two lanes only), SCRATCH, CMP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= 16'd0;
      r_scratch <= 32'd0;
      r_cmp     <= 32'd0;
    end else if (w_mmio_wr) begin
      if (w_off == OFF_LED) begin
        if (sram_we[0]) r_led[7:0]  <= sram_wdata[7:0];
        if (sram_we[1]) r_led[15:8] <= sram_wdata[15:8];
      end
      if (w_off == OFF_SCRATCH) r_scratch <= merge(r_scratch, sram_wdata, sram_we);
      if (w_off == OFF_CMP)     r_cmp     <= merge(r_cmp, sram_wdata, sram_we);
    end
  end

  // Sticky match flag: set has priority over write-1-to-clear
  always_ff @(posedge clk) begin
    if (reset)            r_match <= 1'b0;
    else if (w_match_set) r_match <= 1'b1;
    else if (w_match_clr) r_match <= 1'b0;
  end

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_meta <= 8'd0;
      r_sw_sync <= 8'd0;
    end else begin
      r_sw_meta <= switch_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign sram_rdata  = r_rdata;
  assign led_out     = r_led;
  assign timer_match = r_match;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: RAM byte writes/aliasing, MMIO timer/compare/LED/switch/scratch, reset.
// Latency: each access task returns 1 ns after the sampling edge, when sram_rdata is already valid.
// Backpressure: none in the DUT; the bench issues at most one access per cycle.
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic        timer_match;

  int checks = 0;
  int errors = 0;

  data_sram_responder dut (
    .clk         (clk),
    .reset       (reset),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .switch_in   (switch_in),
    .led_out     (led_out),
    .timer_match (timer_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One strobed access sampled at the next rising edge; returns 1 ns after that edge
  task automatic acc(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    sram_en    = 1'b1;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wd;
    @(posedge clk);
    #1;
    sram_en = 1'b0;
    sram_we = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    sram_en    = 1'b0;
    sram_we    = 4'h0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    switch_in  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_rdata", sram_rdata, 32'h0);
    check("rst_led", {16'h0, led_out}, 32'h0);
    check("rst_match", {31'h0, timer_match}, 32'h0);

    // Uninitialised RAM read must not disturb control outputs
    acc(4'h0, 32'h1c00_0010, 32'h0);
    check("ram_uninit_led", {16'h0, led_out}, 32'h0);
    check("ram_uninit_match", {31'h0, timer_match}, 32'h0);
    // Timer was 0 after the last reset edge, 1 after the RAM read edge
    acc(4'h0, 32'hbfaf_0000, 32'h0);
    check("timer_after_reset", sram_rdata, 32'h1);

    // RAM byte writes with read-before-write
    acc(4'hf, 32'h1c00_0020, 32'h1122_3344);
    acc(4'b0101, 32'h1c00_0020, 32'hAABB_CCDD);
    check("ram_rbw", sram_rdata, 32'h1122_3344);
    acc(4'h0, 32'h1c00_0020, 32'h0);
    check("ram_bytewr", sram_rdata, 32'h11BB_33DD);
    acc(4'h0, 32'h1c00_4020, 32'h0);
    check("ram_alias", sram_rdata, 32'h11BB_33DD);

    // LED
    acc(4'hf, 32'hbfaf_0004, 32'hFFFF_A5A5);
    check("led_out", {16'h0, led_out}, 32'h0000_A5A5);
    acc(4'h0, 32'hbfaf_0004, 32'h0);
    check("led_read", sram_rdata, 32'h0000_A5A5);
    acc(4'b1100, 32'hbfaf_0004, 32'h1234_5678);
    check("led_upper_lanes", {16'h0, led_out}, 32'h0000_A5A5);

    // Timer load and wrap
    acc(4'hf, 32'hbfaf_0000, 32'hFFFF_FFFE);
    acc(4'h0, 32'hbfaf_0000, 32'h0);
    check("timer_rd0", sram_rdata, 32'hFFFF_FFFE);
    acc(4'h0, 32'hbfaf_0000, 32'h0);
    check("timer_rd1", sram_rdata, 32'hFFFF_FFFF);
    acc(4'h0, 32'hbfaf_0000, 32'h0);
    check("timer_wrap0", sram_rdata, 32'h0);
    acc(4'h0, 32'hbfaf_0000, 32'h0);
    check("timer_wrap1", sram_rdata, 32'h1);

    // Compare match: TIMER=0x10 loaded at edge Ec, reaches 0x20 at Ec+16
    acc(4'hf, 32'hbfaf_0010, 32'h0000_0020);
    acc(4'hf, 32'hbfaf_0000, 32'h0000_0010);
    idle(15);
    check("match_before", {31'h0, timer_match}, 32'h0);
    idle(1);
    check("match_rise", {31'h0, timer_match}, 32'h1);
    idle(3);
    check("match_sticky", {31'h0, timer_match}, 32'h1);
    acc(4'h0, 32'hbfaf_0014, 32'h0);
    check("status_read", sram_rdata, 32'h1);
    acc(4'h0, 32'hbfaf_0010, 32'h0);
    check("cmp_read", sram_rdata, 32'h20);
    acc(4'h1, 32'hbfaf_0014, 32'h1);
    check("status_clear", {31'h0, timer_match}, 32'h0);
    // Clear lands in the match cycle: TIMER 0x1E -> 0x1F (idle) -> 0x20 (clear edge)
    acc(4'hf, 32'hbfaf_0000, 32'h0000_001E);
    idle(1);
    check("match_pre_race", {31'h0, timer_match}, 32'h0);
    acc(4'h1, 32'hbfaf_0014, 32'h1);
    check("set_beats_clear", {31'h0, timer_match}, 32'h1);

    // Switch synchronizer: change visible to a read issued two cycles later
    switch_in = 8'h5A;
    acc(4'h0, 32'hbfaf_0008, 32'h0);
    check("sw_cycle0", sram_rdata, 32'h0);
    acc(4'h0, 32'hbfaf_0008, 32'h0);
    check("sw_cycle1", sram_rdata, 32'h0);
    acc(4'h0, 32'hbfaf_0008, 32'h0);
    check("sw_cycle2", sram_rdata, 32'h5A);
    acc(4'hf, 32'hbfaf_0008, 32'hFFFF_FFFF);
    acc(4'h0, 32'hbfaf_0008, 32'h0);
    check("sw_ro", sram_rdata, 32'h5A);

    // Scratch and undefined offset
    acc(4'hf, 32'hbfaf_000C, 32'h1234_5678);
    acc(4'h0, 32'hbfaf_000C, 32'h0);
    check("scratch_rd", sram_rdata, 32'h1234_5678);
    acc(4'hf, 32'hbfaf_0040, 32'hDEAD_BEEF);
    check("undef_wr_rdata", sram_rdata, 32'h0);
    acc(4'h0, 32'hbfaf_0040, 32'h0);
    check("undef_rd", sram_rdata, 32'h0);
    acc(4'h0, 32'hbfaf_000C, 32'h0);
    check("scratch_kept", sram_rdata, 32'h1234_5678);

    // Reset together with a SCRATCH write: reset wins
    sram_en    = 1'b1;
    sram_we    = 4'hf;
    sram_addr  = 32'hbfaf_000C;
    sram_wdata = 32'hCAFE_F00D;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    sram_en = 1'b0;
    sram_we = 4'h0;
    check("midrst_rdata", sram_rdata, 32'h0);
    check("midrst_led", {16'h0, led_out}, 32'h0);
    check("midrst_match", {31'h0, timer_match}, 32'h0);
    acc(4'h0, 32'hbfaf_0000, 32'h0);
    check("midrst_timer", sram_rdata, 32'h0);
    acc(4'h0, 32'hbfaf_000C, 32'h0);
    check("midrst_scratch", sram_rdata, 32'h0);
    acc(4'h0, 32'h1c00_0020, 32'h0);
    check("ram_survives_rst", sram_rdata, 32'h11BB_33DD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
